piso_tx_scheduler: RTL and testbench

PISO_TX_SCHEDULER -- requirements
Module: piso_tx_scheduler

---
 rtl/piso_tx_scheduler_if.sv | 29 ++
 rtl/piso_tx_scheduler.sv | 118 +++++++++++
 tb/tb_piso_tx_scheduler.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/piso_tx_scheduler_if.sv
// Handshake and serial-output bundle between two parallel requesters and the
// PISO transmit scheduler.
interface piso_tx_scheduler_if;
  localparam int unsigned W = 4;

  logic         en;
  logic [W-1:0] in0;
  logic [W-1:0] in1;
  logic         valid0;
  logic         valid1;
  logic         ready0;
  logic         ready1;
  logic         out;
  logic         out_valid;
  logic         first;
  logic         last;
  logic         src;
  logic         busy;

  modport master (
    output en, in0, in1, valid0, valid1,
    input  ready0, ready1, out, out_valid, first, last, src, busy
  );

  modport slave (
    input  en, in0, in1, valid0, valid1,
    output ready0, ready1, out, out_valid, first, last, src, busy
  );
endinterface

// File: rtl/piso_tx_scheduler.sv
// Round-robin arbiter between two 4-bit requesters that serialises the granted
// word MSB first, followed by a programmable idle gap.
module piso_tx_scheduler #(
  parameter int unsigned IDLE_GAP = 1
) (
  input logic               clk,
  input logic               rst,
  piso_tx_scheduler_if.slave bus
);
  localparam int unsigned W  = 4;
  localparam int unsigned CW = 2;
  localparam int unsigned GW = 3;

  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  sr_q, sr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [GW-1:0] gap_q, gap_d;
  logic          ptr_q, ptr_d;
  logic          src_q, src_d;
  logic          first_q, first_d;
  logic          last_q, last_d;
  logic          ov_q, ov_d;
  logic          busy_q, busy_d;
  logic          grant0_c, grant1_c;

  // Ties go to the requester not served last; nothing is granted under reset.
  always_comb begin
    grant0_c = 1'b0;
    grant1_c = 1'b0;
    if (state_q == IDLE && bus.en && !rst) begin
      if (bus.valid0 && bus.valid1) begin
        grant0_c = ptr_q;
        grant1_c = !ptr_q;
      end else begin
        grant0_c = bus.valid0;
        grant1_c = bus.valid1;
      end
    end
  end

  assign bus.ready0    = grant0_c;
  assign bus.ready1    = grant1_c;
  assign bus.out       = sr_q[W-1];
  assign bus.out_valid = ov_q;
  assign bus.first     = first_q;
  assign bus.last      = last_q;
  assign bus.src       = src_q;
  assign bus.busy      = busy_q;

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    gap_d   = gap_q;
    ptr_d   = ptr_q;
    src_d   = src_q;
    first_d = 1'b0;
    last_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (grant0_c || grant1_c) begin
          sr_d    = grant1_c ? bus.in1 : bus.in0;
          src_d   = grant1_c;
          ptr_d   = grant1_c;
          cnt_d   = '0;
          first_d = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        // Four shifts with zero fill leave the register clear for IDLE/GAP.
        sr_d  = {sr_q[W-2:0], 1'b0};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(W - 1)) begin
          gap_d   = '0;
          state_d = (IDLE_GAP > 0) ? GAP : IDLE;
        end else if (cnt_q == CW'(W - 2)) begin
          last_d = 1'b1;
        end
      end
      GAP: begin
        gap_d = gap_q + 1'b1;
        if (gap_q == GW'(IDLE_GAP - 1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    ov_d   = (state_d == SHIFT);
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      gap_q   <= '0;
      ptr_q   <= 1'b1;
      src_q   <= 1'b0;
      first_q <= 1'b0;
      last_q  <= 1'b0;
      ov_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      gap_q   <= gap_d;
      ptr_q   <= ptr_d;
      src_q   <= src_d;
      first_q <= first_d;
      last_q  <= last_d;
      ov_q    <= ov_d;
      busy_q  <= busy_d;
    end
  end
endmodule

// File: tb/tb_piso_tx_scheduler.sv
// Bench for piso_tx_scheduler: two instances (IDLE_GAP 1 and 0) share stimulus
// and are checked every cycle against a frame-schedule reference model.
module tb_piso_tx_scheduler;
  localparam int MAXC = 1024;
  localparam int NDUT = 2;

  logic       clk = 1'b0;
  logic       rst, en, v0, v1;
  logic [3:0] i0, i1;

  int gapv[NDUT] = '{1, 0};
  bit m_ov[NDUT][MAXC];
  bit m_out[NDUT][MAXC];
  bit m_first[NDUT][MAXC];
  bit m_last[NDUT][MAXC];
  bit m_busy[NDUT][MAXC];
  int free_at[NDUT];
  bit m_ptr[NDUT];
  bit m_src[NDUT];
  int cyc, npass, nfail, nchk;

  initial forever #5 clk = ~clk;

  piso_tx_scheduler_if ifa ();
  piso_tx_scheduler_if ifb ();

  assign ifa.en = en;  assign ifa.valid0 = v0;  assign ifa.valid1 = v1;
  assign ifa.in0 = i0; assign ifa.in1 = i1;
  assign ifb.en = en;  assign ifb.valid0 = v0;  assign ifb.valid1 = v1;
  assign ifb.in0 = i0; assign ifb.in1 = i1;

  piso_tx_scheduler #(.IDLE_GAP(1)) dut_a (.clk(clk), .rst(rst), .bus(ifa.slave));
  piso_tx_scheduler #(.IDLE_GAP(0)) dut_b (.clk(clk), .rst(rst), .bus(ifb.slave));

  task automatic chk(input string tag, input int d, input logic obs, input logic exp);
    nchk++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s dut%0d cyc%0d: got %b want %b", tag, d, cyc, obs, exp);
    end
  endtask

  // Model: a grant at cycle c schedules word bits on c+1..c+4, busy through
  // the gap, and frees the scheduler at c+5+gap.
  task automatic eval_dut(input int d);
    logic r0, r1, o, ov, f, l, b, s, g0, g1;
    logic [3:0] word;
    r0 = d == 0 ? ifa.ready0 : ifb.ready0;
    r1 = d == 0 ? ifa.ready1 : ifb.ready1;
    o  = d == 0 ? ifa.out : ifb.out;
    ov = d == 0 ? ifa.out_valid : ifb.out_valid;
    f  = d == 0 ? ifa.first : ifb.first;
    l  = d == 0 ? ifa.last : ifb.last;
    b  = d == 0 ? ifa.busy : ifb.busy;
    s  = d == 0 ? ifa.src : ifb.src;
    g0 = 1'b0;
    g1 = 1'b0;
    if (!rst && en && cyc >= free_at[d]) begin
      if (v0 && v1) begin
        g0 = !m_ptr[d];
        g1 = m_ptr[d];
      end else begin
        g0 = v0;
        g1 = v1;
      end
    end
    chk("ready0", d, r0, g0);
    chk("ready1", d, r1, g1);
    chk("out", d, o, m_out[d][cyc]);
    chk("out_valid", d, ov, m_ov[d][cyc]);
    chk("first", d, f, m_first[d][cyc]);
    chk("last", d, l, m_last[d][cyc]);
    chk("busy", d, b, m_busy[d][cyc]);
    chk("src", d, s, m_src[d]);
    if (rst) begin
      for (int k = 1; k <= 12; k++) begin
        m_ov[d][cyc+k] = 0; m_out[d][cyc+k] = 0; m_first[d][cyc+k] = 0;
        m_last[d][cyc+k] = 0; m_busy[d][cyc+k] = 0;
      end
      free_at[d] = cyc + 1;
      m_ptr[d]   = 1'b0;
      m_src[d]   = 1'b0;
    end else if (g0 || g1) begin
      word = g1 ? i1 : i0;
      for (int k = 0; k < 4; k++) begin
        m_ov[d][cyc+1+k]    = 1;
        m_out[d][cyc+1+k]   = word[3-k];
        m_first[d][cyc+1+k] = (k == 0);
        m_last[d][cyc+1+k]  = (k == 3);
      end
      for (int k = 1; k <= 4 + gapv[d]; k++) m_busy[d][cyc+k] = 1;
      free_at[d] = cyc + 5 + gapv[d];
      m_ptr[d]   = g0;
      m_src[d]   = g1;
    end
  endtask

  // m_ptr holds "requester 1 wins the next tie".
  task automatic run(input int n);
    for (int j = 0; j < n; j++) begin
      #3;
      for (int d = 0; d < NDUT; d++) eval_dut(d);
      cyc++;
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    npass = 0; nfail = 0; nchk = 0; cyc = 0;
    for (int d = 0; d < NDUT; d++) begin
      free_at[d] = 0; m_ptr[d] = 1'b0; m_src[d] = 1'b0;
    end
    rst = 1'b1; en = 1'b0; v0 = 1'b0; v1 = 1'b0; i0 = '0; i1 = '0;
    @(posedge clk);
    #1;
    run(2);
    // single frame 1011 from requester 0
    rst = 1'b0; en = 1'b1; v0 = 1'b1; i0 = 4'b1011;
    run(1);
    v0 = 1'b0;
    run(8);
    // both requesters held: alternating frames
    v0 = 1'b1; v1 = 1'b1; i0 = 4'hA; i1 = 4'h5;
    run(20);
    v0 = 1'b0; v1 = 1'b0;
    run(8);
    // grants blocked while en is low
    en = 1'b0; v1 = 1'b1; i1 = 4'h6;
    run(10);
    en = 1'b1;
    run(1);
    v1 = 1'b0;
    run(8);
    // en dropped during bit 2 of frame C, request kept pending
    v0 = 1'b1; i0 = 4'hC;
    run(1);
    v0 = 1'b0; i0 = 4'h3;
    run(1);
    en = 1'b0; v0 = 1'b1;
    run(10);
    v0 = 1'b0; en = 1'b1;
    run(2);
    // reset during bit 2 of frame F, then a tie
    v0 = 1'b1; i0 = 4'hF;
    run(1);
    v0 = 1'b0;
    run(1);
    rst = 1'b1;
    run(1);
    rst = 1'b0; v0 = 1'b1; v1 = 1'b1; i0 = 4'h9; i1 = 4'h6;
    run(1);
    v0 = 1'b0; v1 = 1'b0;
    run(8);
    // back-to-back valid0
    v0 = 1'b1; i0 = 4'h8;
    run(14);
    v0 = 1'b0;
    run(8);
    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      rst = ($urandom_range(0, 59) == 0);
      en  = ($urandom_range(0, 7) != 0);
      v0  = 1'($urandom);
      v1  = 1'($urandom);
      i0  = 4'($urandom);
      i1  = 4'($urandom);
      run(1);
    end
    rst = 1'b0; v0 = 1'b0; v1 = 1'b0;
    run(10);
    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end
endmodule
